mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
Sequencer that drives the 3-bit select of the 8:1 single-bit channel mux and consumes its output. On a start request it visits every channel enabled in a mask, waits a programmable settle time, samples the mux output, and assembles the results into an 8-bit word. The word is delivered downstream over a valid/ready handshake.

Parameters:
SETTLE, 2, idle cycles after each sel change before sampling mux_out (0..15)
CNT_W, 4, width of the settle counter; must satisfy SETTLE < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  scan request, sampled in IDLE only
mask  input  8  channel enable, bit i = channel i; captured on accepted start
sel  output  3  select driven to the 8:1 mux
mux_out  input  1  selected channel bit returned by the mux
busy  output  1  high from accepted start until result accepted
data_out  output  8  assembled result, bit i = channel i
valid  output  1  result available
ready  input  1  downstream accepts result when valid&ready

Behaviour:
- Reset (async assert, sync release): state IDLE; sel=0, busy=0, valid=0, data_out=0, counters 0. Reset mid-scan abandons the scan with no partial result.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: start=1 at edge -> capture mask into mask_q, clear the shadow word, busy=1.
  - mask!=0 -> sel = lowest enabled channel, go to SETTLE.
  - mask==0 -> data_out=0, valid=1, go to DONE. Valid is seen 1 cycle after the start edge.
- SETTLE: count SETTLE cycles, with sel held constant. When the count is reached, or immediately when SETTLE=0, go to SAMPLE.
- SAMPLE: on this edge write shadow[sel]=mux_out.
  - If a higher enabled channel remains in mask_q, set sel to the next enabled channel (disabled channels skipped in zero cycles) and go to SETTLE.
  - Otherwise copy shadow to data_out, valid=1, go to DONE.
- Timing: each enabled channel costs exactly SETTLE+1 cycles. For N enabled channels, valid rises N*(SETTLE+1) cycles after the start edge.
- Channels are scanned in ascending order only. Disabled channel bits in data_out = 0.
- sel changes only on SAMPLE exit or on start acceptance, never inside a settle window. In DONE and IDLE, sel holds its last value.
- DONE: valid=1 and data_out held stable until valid&ready. On that edge valid=0, busy=0, state goes to IDLE. ready may be high before valid; acceptance then occurs on the first valid cycle.
- start while busy is ignored, with no queuing. start on the same edge as acceptance is ignored, so start must be re-asserted in IDLE.
- mask changes during a scan are ignored (mask_q is used).
- data_out only updates on entry to DONE. Intermediate samples go to the shadow register.

Optional Feature:
MUX_SCAN_PARITY_EN:
- Defined: adds output port data_parity (1 bit) = XOR of the data_out bits, updated together with data_out and reset to 0.
- Undefined: the port and its logic are absent, and the port list matches the one above exactly.

Test Plan:
- Full scan: SETTLE=2, mask=8'hFF, bench mux with channels a..h = 0,1,0,0,1,1,0,1 -> sel steps 0..7, each held 3 cycles; valid rises 24 cycles after start; data_out=8'hB2.
- Sparse mask: mask=8'h81, same inputs -> sel visits 0 then 7 only; valid after 6 cycles; data_out=8'h80.
- Empty mask: mask=8'h00, start pulse -> valid=1 one cycle later, data_out=8'h00, sel unchanged.
- Backpressure: hold ready=0 for 5 cycles after valid and pulse start meanwhile -> data_out and valid stable, no new scan. Raise ready -> valid=0 and busy=0 next cycle.
- Reset mid-scan: assert rst_n=0 while sel=3 in a mask=8'hFF scan -> outputs immediately 0. After release, a new start gives a correct full result.
- Parity (MUX_SCAN_PARITY_EN): full-scan case -> data_parity=0. With mask=8'h02 and b=1 -> data_out=8'h02, data_parity=1.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 single-bit channel mux: walks enabled channels, settles, samples, and delivers an 8-bit word.
// Optional MUX_SCAN_PARITY_EN adds a data_parity output (XOR of data_out).
module mux_scan_ctrl #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  input  logic       mux_out,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       data_parity
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  // With no settle time a new select goes straight to sampling.
  localparam state_t POST_SEL = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

  state_t           state;
  logic [7:0]       mask_q;
  logic [7:0]       shadow;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       first_ch;
  logic [3:0]       next_ch;
  logic [7:0]       word;

  // Returns {found, index} of the lowest set bit of m at or above position from.
  function automatic logic [3:0] find_ch(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  always_comb begin
    first_ch  = find_ch(mask, 4'd0);
    next_ch   = find_ch(mask_q, {1'b0, sel} + 4'd1);
    word      = shadow;
    word[sel] = mux_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sel      <= 3'd0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data_out <= 8'd0;
      mask_q   <= 8'd0;
      shadow   <= 8'd0;
      cnt      <= '0;
`ifdef MUX_SCAN_PARITY_EN
      data_parity <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q <= mask;
            shadow <= 8'd0;
            busy   <= 1'b1;
            cnt    <= '0;
            if (first_ch[3]) begin
              sel   <= first_ch[2:0];
              state <= POST_SEL;
            end else begin
              data_out <= 8'd0;
              valid    <= 1'b1;
              state    <= S_DONE;
`ifdef MUX_SCAN_PARITY_EN
              data_parity <= 1'b0;
`endif
            end
          end
        end
        S_SETTLE: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          shadow <= word;
          if (next_ch[3]) begin
            sel   <= next_ch[2:0];
            state <= POST_SEL;
          end else begin
            data_out <= word;
            valid    <= 1'b1;
            state    <= S_DONE;
`ifdef MUX_SCAN_PARITY_EN
            data_parity <= ^word;
`endif
          end
        end
        S_DONE: begin
          if (ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
